// File: rtl/conv_sched.sv
// conv_sched - scheduler for the PHY parallel-to-serial converter.
//
// Accepts parallel words over a valid/ready handshake, latches a width mode
// per word and issues a one-cycle load strobe to the converter. It then
// tracks the serial bit index so the next word loads exactly on the word
// boundary, with no bubble between words.
//
// Width modes (i_pclk_req / o_pclk): 00 = 32 bit, 01 = 16 bit, 10 = 8 bit.
// The reserved code 11 keeps the previous mode and raises o_err for one cycle.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_enb       global enable; low freezes all state
//   i_pclk_req  requested width mode for the next word
//   i_in        upstream parallel word
//   i_in_valid  upstream word valid
//   o_in_ready  scheduler can accept a word this cycle (combinational)
//   o_pclk      width mode applied to the converter
//   o_data      word presented to the converter, masked to the width
//   o_load      one-cycle load strobe for the converter
//   o_bit_idx   index of the bit being serialized
//   o_shifting  high while a word is being serialized
//   o_err       one-cycle pulse when a word is accepted with mode 11
//   o_word_cnt  count of accepted words (wraps)
//
// DATA_W must be 32: the width modes are defined relative to a 32-bit word.

module conv_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enb,
  input  logic [1:0]        i_pclk_req,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [1:0]        o_pclk,
  output logic [DATA_W-1:0] o_data,
  output logic              o_load,
  output logic [4:0]        o_bit_idx,
  output logic              o_shifting,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_word_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_pclk;
  logic [DATA_W-1:0]  r_data;
  logic               r_load;
  logic [4:0]         r_bit_idx;
  logic               r_err;
  logic [CNT_W-1:0]   r_word_cnt;

  state_t             w_state_next;
  logic [1:0]         w_pclk_next;
  logic [DATA_W-1:0]  w_data_next;
  logic               w_load_next;
  logic [4:0]         w_bit_idx_next;
  logic               w_err_next;
  logic [CNT_W-1:0]   w_word_cnt_next;

  logic [4:0]         w_last_idx;
  logic               w_last;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_req_illegal;
  logic [1:0]         w_pclk_sel;

  // Keep-ones mask for a given width mode.
  function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] mode);
    logic [DATA_W-1:0] m;
    case (mode)
      2'b01:   m = {{(DATA_W-16){1'b0}}, {16{1'b1}}};
      2'b10:   m = {{(DATA_W-8){1'b0}}, {8{1'b1}}};
      default: m = {DATA_W{1'b1}};
    endcase
    return m;
  endfunction

  // Final bit index of the word in flight (N-1). Mode 11 is never latched,
  // so its entry only exists to keep the decode total.
  always_comb begin
    case (r_pclk)
      2'b01:   w_last_idx = 5'd15;
      2'b10:   w_last_idx = 5'd7;
      default: w_last_idx = 5'd31;
    endcase
  end

  assign w_last        = (r_bit_idx == w_last_idx);
  assign w_in_ready    = i_enb & ((r_state == IDLE) | ((r_state == SHIFT) & w_last));
  assign w_accept      = i_in_valid & w_in_ready;
  assign w_req_illegal = (i_pclk_req == 2'b11);
  // An illegal request keeps the current mode rather than guessing one.
  assign w_pclk_sel    = w_req_illegal ? r_pclk : i_pclk_req;

  always_comb begin
    // Hold everything by default; strobes drop unless re-asserted.
    w_state_next    = r_state;
    w_pclk_next     = r_pclk;
    w_data_next     = r_data;
    w_load_next     = 1'b0;
    w_bit_idx_next  = r_bit_idx;
    w_err_next      = 1'b0;
    w_word_cnt_next = r_word_cnt;

    if (i_enb) begin
      if (w_accept) begin
        w_state_next    = SHIFT;
        w_pclk_next     = w_pclk_sel;
        w_data_next     = i_in & width_mask(w_pclk_sel);
        w_load_next     = 1'b1;
        w_bit_idx_next  = 5'd0;
        w_err_next      = w_req_illegal;
        w_word_cnt_next = r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (r_state == SHIFT) begin
        if (w_last) begin
          // Word finished with nothing queued behind it.
          w_state_next   = IDLE;
          w_bit_idx_next = 5'd0;
        end else begin
          w_bit_idx_next = r_bit_idx + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_pclk     <= 2'b00;
      r_data     <= '0;
      r_load     <= 1'b0;
      r_bit_idx  <= 5'd0;
      r_err      <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pclk     <= w_pclk_next;
      r_data     <= w_data_next;
      r_load     <= w_load_next;
      r_bit_idx  <= w_bit_idx_next;
      r_err      <= w_err_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  assign o_in_ready = w_in_ready;
  assign o_pclk     = r_pclk;
  assign o_data     = r_data;
  assign o_load     = r_load;
  assign o_bit_idx  = r_bit_idx;
  assign o_shifting = (r_state == SHIFT);
  assign o_err      = r_err;
  assign o_word_cnt = r_word_cnt;

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Scheduler for the PHY parallel-to-serial converter.
- Accepts parallel words from upstream over a valid/ready handshake and latches a width mode per word (PCLK: 00=32 b, 01=16 b, 10=8 b).
- Issues a one-cycle LOAD strobe to the converter, then tracks the serial bit index so the next word is loaded exactly on the word boundary.
- Sits between the link-layer word source and the converter; drives the converter's PCLK, data and load inputs.

Parameters:
- DATA_W, 32, parallel word width; must be 32.
- CNT_W, 16, width of the transmitted-word counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENB  in  1  global enable; low freezes all state.
- PCLK_REQ  in  2  requested width mode for the next word.
- in  in  DATA_W  upstream parallel word.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  scheduler can accept a word this cycle.
- PCLK  out  2  width mode applied to the converter.
- DATA  out  DATA_W  word presented to the converter, masked to width.
- LOAD  out  1  one-cycle strobe; converter loads DATA.
- BIT_IDX  out  5  index of the bit being serialized.
- SHIFTING  out  1  state==SHIFT.
- ERR  out  1  one-cycle pulse when a word is accepted with PCLK_REQ=11.
- WORD_CNT  out  CNT_W  count of accepted words; wraps.

Behaviour:
- Reset (async, immediate, any state, mid-word included): state=IDLE, PCLK=00, DATA=0, LOAD=0, BIT_IDX=0, ERR=0, WORD_CNT=0. A partially sent word is dropped, with no resume.
- N = 32/16/8 for the latched PCLK = 00/01/10.
- IN_READY is combinational: ENB & (state==IDLE | (state==SHIFT & BIT_IDX==N-1)). It is never high while ENB=0.
- Accept = IN_VALID & IN_READY at a rising edge. On the next cycle:
  - LOAD=1 for exactly one cycle, BIT_IDX=0, state=SHIFT, WORD_CNT+1.
  - PCLK = PCLK_REQ if PCLK_REQ≠11; otherwise PCLK keeps its previous value and ERR=1 for one cycle.
  - DATA = in masked to the new N: bits above N-1 forced to 0.
- States:
  - IDLE: waits for accept.
  - SHIFT, while ENB=1: BIT_IDX increments by 1 per cycle.
  - SHIFT at BIT_IDX==N-1: accept goes back to BIT_IDX=0 with LOAD (back-to-back, no bubble); no accept goes to IDLE with BIT_IDX=0 and SHIFTING=0.
- Each word occupies exactly N cycles in SHIFT. Throughput is one bit per cycle when upstream is always valid.
- PCLK_REQ changes mid-word have no effect; the mode is sampled only at accept. PCLK and DATA are stable from LOAD until the next accept.
- ENB=0: all registers hold and LOAD=0. LOAD is never re-asserted on resume. Counting continues from the held BIT_IDX when ENB returns.
- IN_VALID with ENB=0: no accept; upstream must hold the word.
- WORD_CNT wraps from 2^CNT_W-1 to 0 silently.
- LOAD and ERR are never high for more than one consecutive cycle unless there are back-to-back accepts.

Test Plan:
- Reset/idle: assert RESET mid-SHIFT (BIT_IDX=7) -> all outputs are at reset values immediately; after release, IN_READY=1 once ENB=1.
- 32-bit word: ENB=1, PCLK_REQ=00, in=0x0F00FF55, IN_VALID one cycle -> LOAD one cycle, DATA=0x0F00FF55, PCLK=00, BIT_IDX 0..31, then IDLE; WORD_CNT=1.
- Mode change back-to-back: the 32 b word above, then PCLK_REQ=01 with in=0x000030EA held valid -> at BIT_IDX=31 IN_READY=1, next cycle LOAD=1, PCLK=01, DATA=0x000030EA, BIT_IDX 0..15. Then PCLK_REQ=10, in=0xFFFFFFAE -> DATA=0x000000AE, 8 cycles.
- Mid-word request: during a 16 b word, toggle PCLK_REQ to 10 at BIT_IDX=5 -> PCLK stays 01 and the word still takes 16 cycles.
- Illegal mode: PCLK_REQ=11 on accept with current PCLK=01 -> ERR pulses one cycle, PCLK=01, 16-cycle word.
- ENB stall: drop ENB at BIT_IDX=10 for 5 cycles -> BIT_IDX holds 10, IN_READY=0, LOAD=0. On resume it continues 11..N-1 with no extra LOAD.
